// File: rtl/run_controller.sv
// Run/pause/step/halt sequencer for a CPU, with a RUN-mode clock divider,
// a single PC breakpoint and saturating instruction statistics.
module run_controller #(
  parameter int RUN_DIV = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             step,
  input  logic             halt,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             branched,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_en,
  input  logic             clr_stats,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int              DIV_W    = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           cur;
  state_t           nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             bp_skip;
  logic             tick;
  logic             bp_hit;

  assign tick   = (div_cnt == DIV_LAST);
  assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
  assign state  = cur;

  // Halt and the breakpoint veto the commit in the very cycle they appear.
  always_comb begin
    cpu_en = 1'b0;
    case (cur)
      ST_RUN:  cpu_en = tick && !halt && !bp_hit;
      ST_STEP: cpu_en = !halt;
      default: cpu_en = 1'b0;
    endcase
  end

  always_comb begin
    nxt = cur;
    if (halt && cur != ST_HALT) begin
      nxt = ST_HALT;
    end else begin
      case (cur)
        ST_PAUSE: begin
          if (go)        nxt = ST_RUN;
          else if (step) nxt = ST_STEP;
        end
        ST_RUN: begin
          if ((tick && bp_hit) || go) nxt = ST_PAUSE;
        end
        ST_STEP: nxt = ST_PAUSE;
        default: nxt = ST_HALT;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= ST_PAUSE;
      div_cnt    <= '0;
      bp_skip    <= 1'b0;
      inst_cnt   <= '0;
      jump_cnt   <= '0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      cur     <= nxt;
      div_cnt <= (cur == ST_RUN && nxt == ST_RUN && !tick) ? div_cnt + DIV_W'(1) : '0;

      // Leaving PAUSE arms the skip so a resume at the breakpoint executes it once.
      if (cur == ST_PAUSE && (nxt == ST_RUN || nxt == ST_STEP)) bp_skip <= 1'b1;
      else if (cpu_en)                                          bp_skip <= 1'b0;

      if (clr_stats) begin
        inst_cnt   <= '0;
        jump_cnt   <= '0;
        branch_cnt <= '0;
        taken_cnt  <= '0;
      end else if (cpu_en) begin
        inst_cnt   <= bump(inst_cnt, 1'b1);
        jump_cnt   <= bump(jump_cnt, is_jump);
        branch_cnt <= bump(branch_cnt, is_branch);
        taken_cnt  <= bump(taken_cnt, is_branch && branched);
      end
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: three instances (div 1, div 4, 4-bit counters) share
// stimulus; a per-cycle reference model feeds an expected queue drained at negedge.
module tb_run_controller;

  localparam int W = 133;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go, step, halt, is_jump, is_branch, branched, bp_en, clr_stats;
  logic [31:0] bp_addr;
  logic [31:0] pc_a, pc_b, pc_c;
  logic        en_a, en_b, en_c;
  logic [1:0]  st_a, st_b, st_c;
  logic [31:0] inst_a, jump_a, br_a, tk_a;
  logic [31:0] inst_b, jump_b, br_b, tk_b;
  logic [3:0]  inst_c, jump_c, br_c, tk_c;

  run_controller #(.RUN_DIV(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .go(go), .step(step), .halt(halt),
    .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
    .pc(pc_a), .bp_addr(bp_addr), .bp_en(bp_en), .clr_stats(clr_stats),
    .cpu_en(en_a), .state(st_a),
    .inst_cnt(inst_a), .jump_cnt(jump_a), .branch_cnt(br_a), .taken_cnt(tk_a)
  );

  run_controller #(.RUN_DIV(4), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .go(go), .step(step), .halt(halt),
    .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
    .pc(pc_b), .bp_addr(bp_addr), .bp_en(bp_en), .clr_stats(clr_stats),
    .cpu_en(en_b), .state(st_b),
    .inst_cnt(inst_b), .jump_cnt(jump_b), .branch_cnt(br_b), .taken_cnt(tk_b)
  );

  run_controller #(.RUN_DIV(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .go(go), .step(step), .halt(halt),
    .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
    .pc(pc_c), .bp_addr(bp_addr), .bp_en(bp_en), .clr_stats(clr_stats),
    .cpu_en(en_c), .state(st_c),
    .inst_cnt(inst_c), .jump_cnt(jump_c), .branch_cnt(br_c), .taken_cnt(tk_c)
  );

  // Reference model: mode 0..3 = PAUSE/RUN/STEP/HALT, m_run = cycles spent in RUN since entry.
  int          m_state[3];
  int          m_run[3];
  int          m_div[3];
  int          m_w[3];
  bit          m_skip[3];
  longint      m_cnt[3][4];
  logic [31:0] m_pc[3];

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic        h_lvl, bpen_v;
  logic [31:0] bpaddr_v;
  logic [1:0]  flag_force;

  function automatic void model_step(input int i);
    bit     tick, hit, en;
    int     nxt;
    longint cap;
    logic [W-1:0] e;
    cap  = (longint'(1) << m_w[i]) - 1;
    tick = (m_run[i] % m_div[i]) == (m_div[i] - 1);
    hit  = bp_en && (m_pc[i] == bp_addr) && !m_skip[i];
    en   = (m_state[i] == 1 && tick && !halt && !hit) || (m_state[i] == 2 && !halt);
    e = {2'(i), en, 2'(m_state[i]), 32'(m_cnt[i][0]), 32'(m_cnt[i][1]),
         32'(m_cnt[i][2]), 32'(m_cnt[i][3])};
    exp_q.push_back(e);
    if (rst) begin
      m_state[i] = 0;
      m_run[i]   = 0;
      m_skip[i]  = 0;
      m_pc[i]    = 32'd0;
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      return;
    end
    if (clr_stats) begin
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
    end else if (en) begin
      if (m_cnt[i][0] < cap) m_cnt[i][0]++;
      if (is_jump && m_cnt[i][1] < cap) m_cnt[i][1]++;
      if (is_branch && m_cnt[i][2] < cap) m_cnt[i][2]++;
      if (is_branch && branched && m_cnt[i][3] < cap) m_cnt[i][3]++;
    end
    if (en) begin
      m_skip[i] = 0;
      m_pc[i]   = m_pc[i] + 32'd4;
    end
    nxt = m_state[i];
    if (halt && m_state[i] != 3)                nxt = 3;
    else if (m_state[i] == 1 && tick && hit)    nxt = 0;
    else if (m_state[i] == 0 && go)   begin nxt = 1; m_skip[i] = 1; end
    else if (m_state[i] == 0 && step) begin nxt = 2; m_skip[i] = 1; end
    else if (m_state[i] == 1 && go)             nxt = 0;
    else if (m_state[i] == 2)                   nxt = 0;
    m_run[i]   = (m_state[i] == 1 && nxt == 1) ? m_run[i] + 1 : 0;
    m_state[i] = nxt;
  endfunction

  task automatic cycle(input logic g, input logic s, input logic c, input logic r);
    @(posedge clk);
    #1;
    go = g; step = s; clr_stats = c; rst = r;
    halt = h_lvl; bp_en = bpen_v; bp_addr = bpaddr_v;
    case (flag_force)
      2'd1: begin is_jump = 1'b0; is_branch = 1'b0; branched = 1'b0; end
      2'd2: begin is_jump = 1'b1; is_branch = 1'b1; branched = 1'b1; end
      default: begin
        is_jump   = 1'($urandom_range(0, 1));
        is_branch = 1'($urandom_range(0, 1));
        branched  = 1'($urandom_range(0, 1));
      end
    endcase
    pc_a = m_pc[0]; pc_b = m_pc[1]; pc_c = m_pc[2];
    for (int i = 0; i < 3; i++) model_step(i);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle's expectations are compared against live DUT outputs.
  initial begin
    logic [W-1:0] e;
    logic [130:0] a;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e[132:131])
          2'd0:    a = {en_a, st_a, inst_a, jump_a, br_a, tk_a};
          2'd1:    a = {en_b, st_b, inst_b, jump_b, br_b, tk_b};
          default: a = {en_c, st_c, 32'(inst_c), 32'(jump_c), 32'(br_c), 32'(tk_c)};
        endcase
        checks++;
        if (a !== e[130:0]) begin
          errors++;
          $display("FAIL sb dut%0d t=%0t: got en=%0b st=%0d cnt=%0d/%0d/%0d/%0d, expected en=%0b st=%0d cnt=%0d/%0d/%0d/%0d",
                   e[132:131], $time, a[130], a[129:128], a[127:96], a[95:64], a[63:32], a[31:0],
                   e[130], e[129:128], e[127:96], e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; go = 1'b0; step = 1'b0; halt = 1'b0; clr_stats = 1'b0;
    is_jump = 1'b0; is_branch = 1'b0; branched = 1'b0;
    bp_en = 1'b0; bp_addr = 32'd0; pc_a = 32'd0; pc_b = 32'd0; pc_c = 32'd0;
    h_lvl = 1'b0; bpen_v = 1'b0; bpaddr_v = 32'd0; flag_force = 2'd0;
    m_div = '{1, 4, 1};
    m_w   = '{32, 32, 4};
    for (int i = 0; i < 3; i++) begin
      m_state[i] = 0; m_run[i] = 0; m_skip[i] = 0; m_pc[i] = 32'd0;
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
    end

    // Continuous run at full rate: go, ten cycles, go.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("run11_inst", inst_a, 32'd11);
    check("run11_state", 32'(st_a), 32'd0);
    check("run11_en_off", 32'(en_a), 32'd0);

    // Divided run: four commits in sixteen RUN cycles.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    repeat (16) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("div4_inst", inst_b, 32'd4);
    check("div4_en", 32'(en_b), 32'd0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Breakpoint at 0x10, then resume through it.
    bpen_v = 1'b1; bpaddr_v = 32'h10;
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("bp_hit_en", 32'(en_a), 32'd0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("bp_state", 32'(st_a), 32'd0);
    check("bp_inst", inst_a, 32'd4);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("bp_resume_en", 32'(en_a), 32'd1);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("bp_resume_inst", inst_a, 32'd5);
    check("bp_resume_state", 32'(st_a), 32'd1);
    bpen_v = 1'b0;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // go beats step; single step; step ignored in RUN.
    cycle(0, 0, 0, 1);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("go_wins_state", 32'(st_a), 32'd1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("step_state", 32'(st_a), 32'd2);
    check("step_en", 32'(en_a), 32'd1);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("step_back_state", 32'(st_a), 32'd0);
    check("step_back_en", 32'(en_a), 32'd0);
    check("step_inst", inst_a, 32'd3);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("step_in_run", 32'(st_a), 32'd1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Halt in RUN while a taken branch is presented.
    cycle(0, 0, 0, 1);
    flag_force = 2'd1;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    h_lvl = 1'b1; flag_force = 2'd2;
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("halt_en", 32'(en_a), 32'd0);
    h_lvl = 1'b0; flag_force = 2'd0;
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("halt_state", 32'(st_a), 32'd3);
    check("halt_inst", inst_a, 32'd1);
    check("halt_branch", br_a, 32'd0);
    check("halt_taken", tk_a, 32'd0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("halt_sticky", 32'(st_a), 32'd3);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("rst_state", 32'(st_a), 32'd0);
    check("rst_inst", inst_a, 32'd0);
    check("rst_en", 32'(en_a), 32'd0);

    // Saturation of 4-bit counters, then clear concurrent with a commit.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    repeat (20) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("sat_inst", 32'(inst_c), 32'd15);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    check("clr_inst", 32'(inst_c), 32'd0);
    check("clr_jump", 32'(jump_c), 32'd0);
    check("clr_branch", 32'(br_c), 32'd0);

    // Randomized traffic.
    cycle(0, 0, 0, 1);
    for (int n = 0; n < 2000; n++) begin
      if (n % 64 == 0) begin
        bpen_v   = 1'($urandom_range(0, 1));
        bpaddr_v = 32'(4 * $urandom_range(0, 12));
      end
      if (!h_lvl && $urandom_range(0, 299) == 0) h_lvl = 1'b1;
      else if (h_lvl && $urandom_range(0, 9) == 0) h_lvl = 1'b0;
      cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 149) == 0));
    end
    @(negedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter RUN_DIV, default 1, meaning the CPU enable period in RUN, in clocks (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of each statistics counter.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the synchronous, active-high reset.
REQ-005 SHALL have port go  input  1  meaning a one-cycle pulse that toggles RUN/PAUSE.
REQ-006 SHALL have port step  input  1  meaning a one-cycle pulse requesting execution of exactly one instruction.
REQ-007 SHALL have port halt  input  1  meaning the level-sensitive CPU halt flag from the syscall unit.
REQ-008 SHALL have ports is_jump, is_branch, branched  input  1 each  meaning the CPU control flags for the current instruction.
REQ-009 SHALL have ports pc, bp_addr  input  32 each  meaning the current CPU byte PC and the breakpoint byte address.
REQ-010 SHALL have port bp_en  input  1  meaning breakpoint enable.
REQ-011 SHALL have port clr_stats  input  1  meaning a one-cycle pulse that zeroes all statistics counters.
REQ-012 SHALL have port cpu_en  output  1  meaning the CPU enable; the CPU commits one instruction on each clock edge where it is 1.
REQ-013 SHALL have port state  output  2  meaning the current state: PAUSE=0, RUN=1, STEP=2, HALT=3.
REQ-014 SHALL have ports inst_cnt, jump_cnt, branch_cnt, taken_cnt  output  CNT_W each  meaning the statistics counters.

Function
REQ-015 SHALL hold a registered state and a divider counter div_cnt; cpu_en SHALL be a combinational decode of the registered state, div_cnt, halt, pc and bp signals.
REQ-016 tick SHALL equal (div_cnt == RUN_DIV-1); in RUN, div_cnt SHALL increment each cycle, wrap to 0 after RUN_DIV-1, and be held at 0 in every other state.
REQ-017 bp_hit SHALL equal bp_en && (pc == bp_addr) && !bp_skip.
REQ-018 In RUN, cpu_en SHALL equal tick && !halt && !bp_hit.
REQ-019 In STEP, cpu_en SHALL equal !halt; cpu_en SHALL be 0 in PAUSE and in HALT.
REQ-020 Transitions SHALL follow this priority, highest first:
 - halt=1 in any non-HALT state -> HALT, with cpu_en=0 in that same cycle.
 - RUN && tick && bp_hit -> PAUSE; the instruction at bp_addr SHALL NOT execute.
 - go in PAUSE -> RUN; go in RUN -> PAUSE; cpu_en in that cycle follows the RUN rules.
 - step in PAUSE -> STEP; STEP -> PAUSE after exactly one cycle.
REQ-021 step SHALL be ignored in RUN, STEP and HALT; go SHALL be ignored in STEP and HALT; when go and step coincide in PAUSE, go SHALL win.
REQ-022 HALT SHALL be exited only by rst.
REQ-023 bp_skip SHALL be set on entry to RUN or STEP from PAUSE, and cleared on the first cycle with cpu_en=1; resuming at a breakpoint therefore executes that instruction once.
REQ-024 The breakpoint SHALL be ignored in STEP.
REQ-025 On a cycle with cpu_en=1, inst_cnt SHALL increment by 1.
REQ-026 On a cycle with cpu_en=1, jump_cnt SHALL increment if is_jump, branch_cnt SHALL increment if is_branch, and taken_cnt SHALL increment if is_branch && branched.
REQ-027 Each counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 clr_stats SHALL zero all four counters at the next edge, and SHALL take priority over a simultaneous increment (result 0).
REQ-029 Counters SHALL NOT be affected by go, step or state changes.

Reset
REQ-030 While rst=1 at a clock edge: state SHALL become PAUSE (0), div_cnt=0, bp_skip=0, and all counters=0.
REQ-031 rst SHALL override every other input; cpu_en SHALL read 0 in the cycle after any reset edge.
REQ-032 rst asserted mid-RUN or mid-STEP SHALL abort the operation, with no partial counter update on that edge.

Verification
REQ-033 Scenario: RUN_DIV=1, reset, pulse go, hold 10 cycles, pulse go -> cpu_en=1 for 11 consecutive cycles (the RUN entry through the go-pulse cycle), inst_cnt=11, state=PAUSE.
REQ-034 Scenario: RUN_DIV=4, go, 16 cycles -> cpu_en pulses on every 4th cycle after entry, inst_cnt=4.
REQ-035 Scenario: bp_en=1, bp_addr=0x10, RUN with pc stepping by 4 from 0 -> PAUSE with pc=0x10 and inst_cnt=4; a following go executes 0x10 then continues running.
REQ-036 Scenario: in PAUSE, step asserted with go in the same cycle -> RUN; a separate step -> exactly one cpu_en cycle, then PAUSE; step while in RUN -> no effect.
REQ-037 Scenario: halt=1 in RUN with is_branch=branched=1 -> cpu_en=0 in that cycle, state=HALT, counters unchanged; go and step then have no effect; rst -> PAUSE with counters=0.
REQ-038 Scenario: CNT_W=4, run 20 instructions -> inst_cnt=15; clr_stats concurrent with a commit -> all counters=0.
